md_unit: RTL and testbench
==========================

# md_unit

Multiply/divide unit for the five-stage MIPS pipeline. It lives in the EX stage and owns the HI and LO registers. It executes mult/multu/div/divu with a fixed multi-cycle latency, performs mthi/mtlo writes, and supplies the HI/LO value that EX latches into the EX/MEM register for mfhi/mflo. Its `busy` output, together with a start pulse, feeds the hazard unit so that the pipeline stalls any MD instruction that reaches D while an operation is in flight.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles for div/divu.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_md_op`  in  4  operation code from the shared package: `MD_NONE`, `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`, `MD_MTHI`, `MD_MTLO`. Sampled every rising edge.
- `in_A`  in  32  rs operand; also the mthi/mtlo data.
- `in_B`  in  32  rt operand.
- `in_rd_hi`  in  1  read select: 1 selects HI, 0 selects LO.
- `out_HI_LO`  out  32  combinational read: HI when `in_rd_hi`=1, otherwise LO. Drives `in_HI_LO` of EX/MEM.
- `out_HI`  out  32  current HI register.
- `out_LO`  out  32  current LO register.
- `busy`  out  1  high while an operation is pending.
- `start`  out  1  combinational; high when `in_md_op` is one of mult/multu/div/divu and `busy`=0.

## Operation
- State: `IDLE` and `BUSY`. Registers: `HI`, `LO`, `cnt` (width ≥ clog2(DIV_CYCLES+1)), `tmp_hi`, `tmp_lo`, `div0` flag.
- IDLE, start accepted:
  - compute the full result combinationally from `in_A`/`in_B`;
  - latch it into `tmp_hi`/`tmp_lo`;
  - load `cnt` with MULT_CYCLES or DIV_CYCLES;
  - go to BUSY.
- BUSY: `cnt` decrements each edge. On the edge where `cnt` goes 1→0:
  - HI←`tmp_hi`, LO←`tmp_lo`, except when `div0`=1, in which case HI/LO are unchanged;
  - return to IDLE.
- Arithmetic:
  - mult: signed 32×32→64; HI = [63:32], LO = [31:0].
  - multu: unsigned 32×32→64; same split.
  - div: LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - 0x80000000 / 0xFFFFFFFF under div gives LO=0x80000000, HI=0.
  - Divisor 0 (div or divu): `div0`=1; the full DIV_CYCLES busy period still runs.
- mthi/mtlo in IDLE: HI (resp. LO) ← `in_A` at the next edge; no busy.
- While BUSY, every `in_md_op` other than `MD_NONE` is ignored: no restart and no HI/LO write. Outside this rule the hazard unit guarantees no such op arrives.
- `in_md_op` carries one op per cycle, so start and mthi/mtlo are mutually exclusive by construction.
- Reset, including mid-operation: HI=0, LO=0, `busy`=0, `cnt`=0, `tmp_*`=0, `div0`=0. Any pending result is discarded.

## Timing
- Start sampled at edge k → `busy`=1 from after edge k through edge k+N, where N = MULT_CYCLES or DIV_CYCLES. That is exactly N cycles high.
- HI/LO update at edge k+N, the same edge on which `busy` falls.
- A start may be accepted at edge k+N+1 at the earliest; back-to-back ops therefore have one idle cycle.
- Before edge k+N, `out_HI`/`out_LO`/`out_HI_LO` show the old values.
- `out_HI_LO` has zero latency with respect to `in_rd_hi` and the registers.
- mthi/mtlo: new value is visible on the cycle after the write edge.

## Structure
- Shared package (`define.v`): the `MD_*` op encodings and the default cycle counts. The decoder and the hazard unit use the same constants.
- No sub-module is needed. The multiplier and divider are inline combinational `*`, `/`, `%` using signed casts.

## Test plan
- mult A=0xFFFFFFFF, B=2 → after 5 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE. `busy` high exactly 5 cycles in each case.
- div A=0xFFFFFFF9 (-7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 cycles. divu A=7, B=2 → LO=3, HI=1.
- mtlo 0x12345678, then mthi 0x9ABCDEF0, then div with B=0 → after 10 busy cycles HI=0x9ABCDEF0, LO=0x12345678, both unchanged.
- mult 3×4 started; at busy cycle 2 drive MD_DIVU and MD_MTHI → both ignored. Final LO=12, HI=0; busy length stays 5.
- mult started; `reset` asserted at busy cycle 3 → next cycle HI=LO=0 and `busy`=0. No later update occurs.
- After mthi 0xCAFEBABE: `in_rd_hi`=1 → `out_HI_LO`=0xCAFEBABE; `in_rd_hi`=0 → `out_HI_LO`=LO. Both checked in the same cycle.

Source files
------------

// File: rtl/md_unit_pkg.sv
// Shared multiply/divide definitions: op encodings, default latencies, FSM states.
package md_unit_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6
  } md_op_e;

  localparam int unsigned MD_MULT_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // True for the ops that occupy the unit for multiple cycles.
  function automatic logic md_is_start_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit owning HI/LO; fixed-latency mult/div, mthi/mtlo writes.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  in_md_op,
  input  logic [31:0] in_A,
  input  logic [31:0] in_B,
  input  logic        in_rd_hi,
  output logic [31:0] out_HI_LO,
  output logic [31:0] out_HI,
  output logic [31:0] out_LO,
  output logic        busy,
  output logic        start
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES < 1) ? 1 : $clog2(MAX_CYCLES + 1);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [31:0]        tmp_hi_q, tmp_hi_d, tmp_lo_q, tmp_lo_d;
  logic               div0_q, div0_d;

  logic               is_div;
  logic               b_zero;
  logic               s_ovf;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        udiv_b, sdiv_b;
  logic signed [31:0] quo_s, rem_s;
  logic [31:0]        quo_u, rem_u;
  logic [31:0]        res_hi, res_lo;

  assign is_div = (in_md_op == MD_DIV) || (in_md_op == MD_DIVU);
  assign b_zero = (in_B == '0);
  assign s_ovf  = (in_A == 32'h8000_0000) && (in_B == 32'hFFFF_FFFF);

  assign prod_s = $signed({{32{in_A[31]}}, in_A}) * $signed({{32{in_B[31]}}, in_B});
  assign prod_u = {32'd0, in_A} * {32'd0, in_B};

  // Divisor forced to 1 for x/0 (result discarded) and for MIN/-1, where A/1
  // yields exactly the architected quotient 0x80000000 with remainder 0.
  assign udiv_b = b_zero ? 32'd1 : in_B;
  assign sdiv_b = (b_zero || s_ovf) ? 32'd1 : in_B;
  assign quo_s  = $signed(in_A) / $signed(sdiv_b);
  assign rem_s  = $signed(in_A) % $signed(sdiv_b);
  assign quo_u  = in_A / udiv_b;
  assign rem_u  = in_A % udiv_b;

  // Result select for the op being started.
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (in_md_op)
      MD_MULT:  begin res_hi = prod_s[63:32];  res_lo = prod_s[31:0]; end
      MD_MULTU: begin res_hi = prod_u[63:32];  res_lo = prod_u[31:0]; end
      MD_DIV:   begin res_hi = rem_s;          res_lo = quo_s;        end
      MD_DIVU:  begin res_hi = rem_u;          res_lo = quo_u;        end
      default:  ;
    endcase
  end

  assign busy      = (state_q == MD_BUSY);
  assign start     = md_is_start_op(in_md_op) && !busy;
  assign out_HI    = hi_q;
  assign out_LO    = lo_q;
  assign out_HI_LO = in_rd_hi ? hi_q : lo_q;

  // Next-state: accept start/mthi/mtlo in IDLE; count down and commit in BUSY.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    tmp_hi_d = tmp_hi_q;
    tmp_lo_d = tmp_lo_q;
    div0_d   = div0_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          tmp_hi_d = res_hi;
          tmp_lo_d = res_lo;
          div0_d   = is_div && b_zero;
          cnt_d    = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          state_d  = MD_BUSY;
        end else if (in_md_op == MD_MTHI) begin
          hi_d = in_A;
        end else if (in_md_op == MD_MTLO) begin
          lo_d = in_A;
        end
      end
      MD_BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = MD_IDLE;
          if (!div0_q) begin
            hi_d = tmp_hi_q;
            lo_d = tmp_lo_q;
          end
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // State and HI/LO registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      tmp_hi_q <= '0;
      tmp_lo_q <= '0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      tmp_hi_q <= tmp_hi_d;
      tmp_lo_q <= tmp_lo_d;
      div0_q   <= div0_d;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: completions checked by a busy-fall monitor.
module tb_md_unit;
  import md_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  md_op;
  logic [31:0] a, b;
  logic        rd_hi;
  logic [31:0] hi_lo, hi, lo;
  logic        busy, start;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t sb[$];

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .in_md_op(md_op), .in_A(a), .in_B(b),
    .in_rd_hi(rd_hi), .out_HI_LO(hi_lo), .out_HI(hi), .out_LO(lo),
    .busy(busy), .start(start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: each busy falling edge is one completed (or reset-aborted) op.
  int  blen  = 0;
  logic pbusy = 1'b0;
  always @(negedge clk) begin
    if (busy === 1'b1) begin
      blen++;
    end else if (pbusy) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_completion: got busy fall expected none");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_hi"},  hi, e.hi);
        check({e.name, "_lo"},  lo, e.lo);
        check({e.name, "_len"}, 32'(blen), 32'(e.len));
      end
      blen = 0;
    end
    pbusy = (busy === 1'b1);
  end

  task automatic do_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
    @(posedge clk); #1;
    md_op = op; a = av; b = bv;
    #1;
    check("start_flag", {31'd0, start}, {31'd0, md_is_start_op(op)});
    @(posedge clk); #1;
    md_op = MD_NONE;
  endtask

  task automatic issue(input string n, input logic [3:0] op, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                       input int len);
    sb.push_back('{n, eh, el, len});
    do_op(op, av, bv);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin @(posedge clk); #1; n++; end
    if (busy) begin
      total++; bad++;
      $display("FAIL busy_timeout: got busy=1 expected 0");
    end
    @(negedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; md_op = MD_NONE; a = '0; b = '0; rd_hi = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    issue("mult",  MD_MULT,  32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);  wait_idle();
    issue("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5);  wait_idle();
    issue("div",   MD_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10); wait_idle();
    issue("divu",  MD_DIVU,  32'd7,         32'd2, 32'd1,         32'd3,         10); wait_idle();
    issue("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 10); wait_idle();

    do_op(MD_MTLO, 32'h1234_5678, '0);
    check("mtlo", lo, 32'h1234_5678);
    do_op(MD_MTHI, 32'h9ABC_DEF0, '0);
    check("mthi", hi, 32'h9ABC_DEF0);
    check("mthi_nobusy", {31'd0, busy}, 32'd0);
    issue("div0", MD_DIV, 32'd5, 32'd0, 32'h9ABC_DEF0, 32'h1234_5678, 10); wait_idle();

    // Ops during busy are ignored.
    issue("ign_mult", MD_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 5);
    @(posedge clk); #1;
    md_op = MD_DIVU; a = 32'd100; b = 32'd7;
    #1 check("start_while_busy", {31'd0, start}, 32'd0);
    @(posedge clk); #1;
    md_op = MD_MTHI; a = 32'h5555_5555;
    @(posedge clk); #1;
    md_op = MD_NONE;
    check("mthi_ignored", hi, 32'h9ABC_DEF0);
    wait_idle();

    do_op(MD_MTHI, 32'hCAFE_BABE, '0);
    rd_hi = 1'b1; #1 check("rd_hi1", hi_lo, 32'hCAFE_BABE);
    rd_hi = 1'b0; #1 check("rd_hi0", hi_lo, 32'd12);

    // Reset in the third busy cycle aborts the op.
    issue("rst_abort", MD_MULT, 32'd3, 32'd4, 32'd0, 32'd0, 3);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    repeat (8) @(posedge clk);
    #1;
    check("abort_hi_late", hi, 32'd0);
    check("abort_lo_late", lo, 32'd0);

    @(negedge clk); #1;
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
